// File: rtl/ysyx_22050019_mdu_pkg.sv
// Shared definitions for the MUL/DIV issue scheduler.
// Op bit indices, unit masks and FSM state encoding.
package ysyx_22050019_mdu_pkg;

    localparam int OP_DIV    = 0;
    localparam int OP_DIVU   = 1;
    localparam int OP_REM    = 2;
    localparam int OP_REMU   = 3;
    localparam int OP_DIVW   = 4;
    localparam int OP_DIVUW  = 5;
    localparam int OP_REMW   = 6;
    localparam int OP_REMUW  = 7;
    localparam int OP_MUL    = 8;
    localparam int OP_MULH   = 9;
    localparam int OP_MULHSU = 10;
    localparam int OP_MULHU  = 11;
    localparam int OP_MULW   = 12;

    localparam logic [12:0] DIV_MASK = 13'h00FF;
    localparam logic [12:0] MUL_MASK = 13'h1F00;
    localparam logic [12:0] W_MASK   = 13'h10F0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE,
        S_DRAIN
    } state_t;

    function automatic logic is_onehot(input logic [12:0] v);
        return (v != 13'd0) && ((v & (v - 13'd1)) == 13'd0);
    endfunction

endpackage

// File: rtl/ysyx_22050019_mdu_wdog.sv
// Busy-cycle watchdog: clearable up-counter with an expiry flag.
// Expiry is flagged while the count sits at TIMEOUT-1.
module ysyx_22050019_mdu_wdog #(
    parameter int TIMEOUT = 128
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/ysyx_22050019_mdu_sched.sv
// Issue/sequencing controller for the shared multi-cycle MUL/DIV units.
// Optional build macro: MDU_DIV0_BYPASS_EN (divide-by-zero bypass).
module ysyx_22050019_mdu_sched
    import ysyx_22050019_mdu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [12:0]     req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            err,
    output logic            mult_valid,
    output logic [4:0]      mult_type,
    input  logic            mult_stall,
    input  logic            mult_ok,
    input  logic [XLEN-1:0] mult_out,
    output logic            div_valid,
    output logic [7:0]      div_type,
    input  logic            div_stall,
    input  logic            div_ok,
    input  logic [XLEN-1:0] div_out,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic            result_ready
);

    state_t          state;
    logic [12:0]     op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            is_mul_q;
    logic            unit_ok;
    logic [XLEN-1:0] unit_out;
    logic            active;
    logic            expire;
    logic            wd_clr;
    logic            div0;
    logic [XLEN-1:0] div0_res;
    logic            unused_stall;

    // Units never back-pressure the result path; stall is informational.
    assign unused_stall = mult_stall ^ div_stall;

    assign is_mul_q = |(op_q & MUL_MASK);
    assign unit_ok  = is_mul_q ? mult_ok : div_ok;
    assign unit_out = is_mul_q ? mult_out : div_out;

    assign active = (state == S_MUL) || (state == S_DIV)
                 || (state == S_DRAIN);
    assign wd_clr = !active || (flush && state != S_DRAIN);

`ifdef MDU_DIV0_BYPASS_EN
    always_comb begin
        div0     = 1'b0;
        div0_res = '1;
        if (|(req_op & DIV_MASK)) begin
            if (|(req_op & W_MASK)) begin
                div0 = (req_b[31:0] == 32'd0);
            end else begin
                div0 = (req_b == '0);
            end
        end
        unique case (1'b1)
            req_op[OP_REM], req_op[OP_REMU]:
                div0_res = req_a;
            req_op[OP_REMW], req_op[OP_REMUW]:
                div0_res = {{(XLEN-32){req_a[31]}}, req_a[31:0]};
            default:
                div0_res = '1;
        endcase
    end
`else
    assign div0     = 1'b0;
    assign div0_res = '0;
`endif

    ysyx_22050019_mdu_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (active),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            resp_data  <= '0;
            err        <= 1'b0;
            mult_valid <= 1'b0;
            div_valid  <= 1'b0;
        end else begin
            err        <= 1'b0;
            mult_valid <= 1'b0;
            div_valid  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        // Malformed ops are swallowed without a response.
                        if (is_onehot(req_op)) begin
                            if (|(req_op & MUL_MASK)) begin
                                state      <= S_MUL;
                                mult_valid <= 1'b1;
                            end else if (div0) begin
                                state     <= S_DONE;
                                resp_data <= div0_res;
                            end else begin
                                state     <= S_DIV;
                                div_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (expire) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else if (unit_ok && flush) begin
                        state <= S_IDLE;
                    end else if (unit_ok) begin
                        state     <= S_DONE;
                        resp_data <= unit_out;
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush || resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (expire) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else if (unit_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state == S_IDLE) && !flush;
    assign resp_valid   = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign result_ready = active;
    assign mult_type    = op_q[12:8];
    assign div_type     = op_q[7:0];
    assign unit_a       = a_q;
    assign unit_b       = b_q;

endmodule

// File: tb/tb_ysyx_22050019_mdu_sched.sv
// Scoreboard bench for the MUL/DIV scheduler with behavioural unit models.
module tb_ysyx_22050019_mdu_sched;

    localparam int XLEN = 64;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid;
    logic            req_ready;
    logic [12:0]     req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;
    logic            err;
    logic            mult_valid;
    logic [4:0]      mult_type;
    logic            mult_stall;
    logic            mult_ok = 1'b0;
    logic [XLEN-1:0] mult_out = '0;
    logic            div_valid;
    logic [7:0]      div_type;
    logic            div_stall;
    logic            div_ok = 1'b0;
    logic [XLEN-1:0] div_out = '0;
    logic [XLEN-1:0] unit_a;
    logic [XLEN-1:0] unit_b;
    logic            result_ready;

    ysyx_22050019_mdu_sched #(
        .XLEN(XLEN),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data),
        .busy(busy), .err(err),
        .mult_valid(mult_valid), .mult_type(mult_type),
        .mult_stall(mult_stall), .mult_ok(mult_ok),
        .mult_out(mult_out),
        .div_valid(div_valid), .div_type(div_type),
        .div_stall(div_stall), .div_ok(div_ok),
        .div_out(div_out),
        .unit_a(unit_a), .unit_b(unit_b),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [XLEN-1:0] sb[$];

    // Unit models: latency 0 means the unit never answers.
    int mul_lat = 3;
    int div_lat = 2;
    int mcnt = 0;
    int dcnt = 0;
    logic [XLEN-1:0] mul_res = '0;
    logic [XLEN-1:0] div_res = '0;

    assign mult_stall = (mcnt != 0);
    assign div_stall  = (dcnt != 0);

    always @(posedge clk) begin
        if (mult_valid) mcnt <= mul_lat;
        else if (mcnt != 0) mcnt <= mcnt - 1;
        mult_ok  <= (mcnt == 1) && !mult_valid;
        mult_out <= mul_res;
        if (div_valid) dcnt <= div_lat;
        else if (dcnt != 0) dcnt <= dcnt - 1;
        div_ok  <= (dcnt == 1) && !div_valid;
        div_out <= div_res;
    end

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got=%h want=none",
                         resp_data);
            end else begin
                logic [XLEN-1:0] e;
                e = sb.pop_front();
                if (resp_data !== e) begin
                    bad++;
                    $display("FAIL resp_data: got=%h want=%h",
                             resp_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [12:0] op, input logic [63:0] a,
                         input logic [63:0] b, output bit ok);
        ok = 0;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got=none want=accept op=%h", op);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got=hang want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        bit got;
        int mv, rv, nb, ec, ne, dv, hs, acc;
        req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
        flush = 0; resp_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_unit_valids", {mult_valid, div_valid}, 0);
        chk("rst_unit_a", unit_a, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        // MUL 7*6, unit latency 3
        mul_lat = 3; mul_res = 64'd42;
        sb.push_back(64'd42);
        issue(13'h0100, 64'd7, 64'd6, ok);
        mv = 0; rv = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mult_valid) begin
                mv++;
                chk("mul_type", mult_type, 5'b00001);
                chk("mul_unit_a", unit_a, 64'd7);
            end
            if (resp_valid && rv < 0) rv = c;
            @(posedge clk);
            #1;
        end
        chk("mul_latency", 64'(rv), 64'd5);
        chk("mul_valid_cycles", 64'(mv), 64'd1);

        // DIV -20/3 with consumer stalled 4 cycles
        div_lat = 2; div_res = 64'hFFFF_FFFF_FFFF_FFFA;
        resp_ready = 0;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        issue(13'h0001, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, ok);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = resp_valid;
            if (!got) begin
                chk("div_busy_rdy", req_ready, 0);
                @(posedge clk);
            end
        end
        chk("div_resp_seen", got, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("div_hold_valid", resp_valid, 1);
            chk("div_hold_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFA);
            chk("div_hold_rdy", req_ready, 0);
        end
        @(posedge clk);
        #1 resp_ready = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("div_after_hs_rdy", req_ready, 1);
        chk("div_after_hs_valid", resp_valid, 0);
        @(posedge clk);
        #1;

        // DIVU flushed into DRAIN, divider answers at cycle 6
        div_lat = 5; div_res = 64'h1234;
        issue(13'h0002, 64'd100, 64'd7, ok);
        for (int c = 0; c < 12; c++) begin
            flush = (c == 2);
            @(negedge clk);
            chk("drain_no_resp", resp_valid, 0);
            if (c >= 3 && c <= 6) chk("drain_rdy_low", req_ready, 0);
            if (c == 7) chk("drain_rdy_back", req_ready, 1);
            @(posedge clk);
            #1;
        end
        flush = 0;

        // Unit never answers: watchdog abort
        mul_lat = 0;
        issue(13'h0100, 64'd1, 64'd1, ok);
        nb = 0; ec = -1; ne = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (err) begin
                ne++;
                if (ec < 0) ec = c;
                chk("wdog_idle", busy, 0);
            end
            @(posedge clk);
            #1;
        end
        chk("wdog_busy_cycles", 64'(nb), 64'd16);
        chk("wdog_err_cycle", 64'(ec), 64'd16);
        chk("wdog_err_pulses", 64'(ne), 64'd1);

`ifdef MDU_DIV0_BYPASS_EN
        sb.push_back(64'hFFFF_FFFF_8000_0005);
        issue(13'h0040, 64'h0000_0000_8000_0005,
              64'hFFFF_FFFF_0000_0000, ok);
        dv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) chk("byp_valid", resp_valid, 1);
            if (div_valid) dv++;
            @(posedge clk);
            #1;
        end
        chk("byp_no_div", 64'(dv), 64'd0);
`else
        div_lat = 1; div_res = 64'hFFFF_FFFF_FFFF_FFFF;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        issue(13'h0002, 64'd55, 64'd0, ok);
        dv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (div_valid) dv++;
            @(posedge clk);
            #1;
        end
        chk("div0_via_unit", 64'(dv), 64'd1);
`endif

        // Malformed ops are dropped
        issue(13'h0003, 64'd1, 64'd2, ok);
        @(negedge clk);
        chk("multi_hot_dropped", busy, 0);
        @(posedge clk);
        #1;
        issue(13'h0000, 64'd1, 64'd2, ok);
        @(negedge clk);
        chk("zero_op_dropped", busy, 0);
        @(posedge clk);
        #1;

        // Flush in IDLE blocks accept
        flush = 1; req_valid = 1; req_op = 13'h0100;
        @(negedge clk);
        chk("idle_flush_rdy", req_ready, 0);
        @(posedge clk);
        #1 flush = 0; req_valid = 0;
        @(negedge clk);
        chk("idle_flush_no_accept", busy, 0);
        @(posedge clk);
        #1;

        // Back-to-back MULW 3*5 then REMU 17%5
        mul_lat = 2; mul_res = 64'd15;
        div_lat = 2; div_res = 64'd2;
        sb.push_back(64'd15);
        sb.push_back(64'd2);
        issue(13'h1000, 64'd3, 64'd5, ok);
        req_valid = 1; req_op = 13'h0008; req_a = 64'd17; req_b = 64'd5;
        hs = -1; acc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp_valid && resp_ready && hs < 0) hs = c;
            if (req_valid && req_ready && acc < 0) acc = c;
            @(posedge clk);
            #1;
            if (acc >= 0) req_valid = 0;
        end
        chk("b2b_first_hs", 64'(hs), 64'd4);
        chk("b2b_second_acc", 64'(acc), 64'd5);

        repeat (5) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_mdu_sched.md
Name: ysyx_22050019_mdu_sched

Overview:
Issue and sequencing controller for the shared multi-cycle MUL/DIV units inside the execute stage. Accepts one M-extension op at a time over a valid/ready port and latches its operands. Launches the correct unit, collects its one-cycle result pulse, and holds the result until the consumer takes it. Also handles pipeline flush, a busy-cycle watchdog, and the optional divide-by-zero bypass.

Parameters:
XLEN, 64, operand/result width
TIMEOUT, 128, max BUSY cycles before watchdog abort (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  op offered
req_ready  out  1  op accepted when req_valid&req_ready
req_op  in  13  one-hot op: [0]DIV [1]DIVU [2]REM [3]REMU [4]DIVW [5]DIVUW [6]REMW [7]REMUW [8]MUL [9]MULH [10]MULHSU [11]MULHU [12]MULW
req_a  in  XLEN  rs1 value
req_b  in  XLEN  rs2 value
flush  in  1  kill in-flight/held op
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_data  out  XLEN  result
busy  out  1  state != IDLE
err  out  1  one-cycle watchdog abort pulse
mult_valid  out  1  launch multiplier
mult_type  out  5  = latched op[12:8]
mult_stall  in  1  multiplier busy
mult_ok  in  1  multiplier result pulse
mult_out  in  XLEN  multiplier result
div_valid  out  1  launch divider
div_type  out  8  = latched op[7:0]
div_stall  in  1  divider busy
div_ok  in  1  divider result pulse
div_out  in  XLEN  divider result
unit_a, unit_b  out  XLEN  latched operands, stable from launch to result
result_ready  out  1  high in MUL/DIV/DRAIN; units never back-pressured

Behaviour:
- Clock/reset: one clock, clk; rst_n is synchronous and active-low.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_data=0; busy=0; err=0; mult_valid=div_valid=0; latched op/operands=0; wd counter=0.
- States: IDLE, MUL, DIV, DONE, DRAIN.
- IDLE:
  - req_ready=1 iff !flush.
  - On accept: latch op/a/b. Go MUL if any op[12:8], else DIV.
  - Op not one-hot (zero or multi-bit): accepted and dropped, no response.
- MUL/DIV:
  - *_valid high in the first cycle of the state only.
  - On *_ok: capture *_out into resp_data, go DONE.
  - Latency from accept to resp_valid = unit latency + 2.
  - An ok from the other unit is ignored.
- DONE:
  - resp_valid=1, resp_data stable.
  - On resp_ready: go IDLE. Accept of the next op is possible the following cycle.
- Flush:
  - In MUL/DIV: go DRAIN.
  - In DONE: go IDLE, result dropped.
  - In IDLE: no accept that cycle.
  - Flush in the same cycle as *_ok in MUL/DIV: result discarded, go IDLE.
- DRAIN: wait for *_ok of the killed op, discard it, go IDLE. req_ready=0 throughout.
- Watchdog:
  - Counter clears on entering MUL/DIV/DRAIN and increments each cycle there.
  - At TIMEOUT-1: err=1 for one cycle, go IDLE, no response.
- resp_valid never drops without resp_ready or flush.
- At most one op is ever in flight.

Optional Feature:
MDU_DIV0_BYPASS_EN:
- Defined: on accept of a div-class op whose divisor is zero (req_b==0; W ops test req_b[31:0]==0), skip the divider and go directly to DONE the next cycle.
  - DIV/DIVU/DIVW/DIVUW return all-ones.
  - REM/REMU return req_a.
  - REMW/REMUW return sign-extended req_a[31:0].
  - div_valid is never asserted for these ops.
- Undefined: every div op goes through the divider.

Decomposition:
- Package ysyx_22050019_mdu_pkg: op bit indices, state encoding, DIV_MASK=13'h00FF, MUL_MASK=13'h1F00, W_MASK.
- One natural sub-module: ysyx_22050019_mdu_wdog (loadable counter with expiry pulse).

Test Plan:
- MUL, a=7, b=6, model multiplier ok after 3 cycles, resp_ready=1 -> resp_data=42; resp_valid exactly 5 cycles after accept; mult_valid exactly 1 cycle.
- DIV, a=-20, b=3, resp_ready held low 4 cycles -> resp_data=-6 held stable all 4 cycles; req_ready=0 until handshake.
- DIVU launched, flush 2 cycles later, div_ok at cycle 6 with 0x1234 -> no resp_valid; req_ready returns the cycle after div_ok.
- Unit never asserts ok, TIMEOUT=16 -> err pulse at busy cycle 16, state IDLE, no response.
- MDU_DIV0_BYPASS_EN, REMW, a=0x0000_0000_8000_0005, b=0xFFFF_FFFF_0000_0000 -> resp_data=0xFFFF_FFFF_8000_0005 the cycle after accept; div_valid stays 0.
- Back-to-back MULW then REMU, consumer always ready -> two responses in order; second accept the cycle after the first handshake.
